// File: rtl/othello_pkg.sv
// Shared Othello definitions: cell encodings, player encoding, direction table
// and the move-validator state set.
package othello_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_BLACK = 2'b01;
    localparam logic [1:0] CELL_WHITE = 2'b10;

    typedef enum logic {
        PLAYER_BLACK = 1'b0,
        PLAYER_WHITE = 1'b1
    } player_t;

    // Order: N, NE, E, SE, S, SW, W, NW
    localparam logic signed [1:0] DIR_DX [8] = '{2'sd0, 2'sd1, 2'sd1, 2'sd1,
                                                 2'sd0, -2'sd1, -2'sd1, -2'sd1};
    localparam logic signed [1:0] DIR_DY [8] = '{-2'sd1, -2'sd1, 2'sd0, 2'sd1,
                                                 2'sd1, 2'sd1, 2'sd0, -2'sd1};

    typedef enum logic [3:0] {
        IDLE,
        RD_TGT,
        CK_TGT,
        DIR_INIT,
        STEP,
        CHECK,
        FLIP,
        NEXT_DIR,
        PLACE,
        ACKS,
        DONE,
        REJECT
    } state_t;

    function automatic logic [1:0] own_cell(input player_t p);
        return (p == PLAYER_WHITE) ? CELL_WHITE : CELL_BLACK;
    endfunction

    function automatic logic [1:0] opp_cell(input player_t p);
        return (p == PLAYER_WHITE) ? CELL_BLACK : CELL_WHITE;
    endfunction

endpackage

// File: rtl/move_validator_dir_step.sv
// Combinational board walker: position plus or minus one direction delta,
// with an off-board flag for the resulting square.
module dir_step
    import othello_pkg::*;
(
    input  logic signed [3:0] pos_x,
    input  logic signed [3:0] pos_y,
    input  logic        [2:0] dir,
    input  logic              reverse,
    output logic signed [3:0] next_x,
    output logic signed [3:0] next_y,
    output logic              off_board
);

    logic signed [3:0] dx;
    logic signed [3:0] dy;

    always_comb begin
        dx = {{2{DIR_DX[dir][1]}}, DIR_DX[dir]};
        dy = {{2{DIR_DY[dir][1]}}, DIR_DY[dir]};
        next_x = reverse ? (pos_x - dx) : (pos_x + dx);
        next_y = reverse ? (pos_y - dy) : (pos_y + dy);
        // Results span -1..8; both -1 and 8 have bit 3 set in 4-bit signed form.
        off_board = next_x[3] | next_y[3];
    end

endmodule

// File: rtl/move_validator.sv
// Validates an Othello move against the board RAM, flips every bracketed
// opponent run, places the disc and acknowledges, or rejects the move.
module move_validator
    import othello_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       new_move,
    input  logic       player,
    input  logic       go,
    input  logic [2:0] cursor_x,
    input  logic [2:0] cursor_y,
    input  logic [1:0] board_rdata,
    output logic [5:0] board_addr,
    output logic [1:0] board_wdata,
    output logic       board_we,
    output logic       ack,
    output logic       invalid,
    output logic       busy
);

    state_t            state;
    player_t           side;
    logic        [2:0] tgt_x;
    logic        [2:0] tgt_y;
    logic        [2:0] dir;
    logic        [2:0] run;
    logic        [2:0] flips;
    logic              any;
    logic signed [3:0] pos_x;
    logic signed [3:0] pos_y;
    logic              pos_off;
    logic              go_q;

    logic        [1:0] own;
    logic        [1:0] opp;
    logic signed [3:0] base_x;
    logic signed [3:0] base_y;
    logic              reverse;
    logic signed [3:0] next_x;
    logic signed [3:0] next_y;
    logic              off_board;

    always_comb begin
        own     = own_cell(side);
        opp     = opp_cell(side);
        base_x  = (state == DIR_INIT) ? {1'b0, tgt_x} : pos_x;
        base_y  = (state == DIR_INIT) ? {1'b0, tgt_y} : pos_y;
        reverse = (state == FLIP) || ((state == CHECK) && (board_rdata == own));
    end

    dir_step u_dir_step (
        .pos_x     (base_x),
        .pos_y     (base_y),
        .dir       (dir),
        .reverse   (reverse),
        .next_x    (next_x),
        .next_y    (next_y),
        .off_board (off_board)
    );

    // board_addr is loaded on entry to RD_TGT/STEP so the read is presented
    // during those states and the data arrives in CK_TGT/CHECK.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            side        <= PLAYER_BLACK;
            tgt_x       <= '0;
            tgt_y       <= '0;
            dir         <= '0;
            run         <= '0;
            flips       <= '0;
            any         <= 1'b0;
            pos_x       <= '0;
            pos_y       <= '0;
            pos_off     <= 1'b0;
            go_q        <= 1'b0;
            board_addr  <= '0;
            board_wdata <= '0;
            board_we    <= 1'b0;
            ack         <= 1'b0;
            invalid     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            go_q     <= go;
            board_we <= 1'b0;
            ack      <= 1'b0;
            invalid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (new_move) begin
                        tgt_x      <= cursor_x;
                        tgt_y      <= cursor_y;
                        side       <= player_t'(player);
                        board_addr <= {cursor_y, cursor_x};
                        busy       <= 1'b1;
                        state      <= RD_TGT;
                    end
                end
                RD_TGT: state <= CK_TGT;
                CK_TGT: begin
                    if (board_rdata != CELL_EMPTY) begin
                        invalid <= 1'b1;
                        busy    <= 1'b0;
                        state   <= REJECT;
                    end else begin
                        dir   <= '0;
                        any   <= 1'b0;
                        state <= DIR_INIT;
                    end
                end
                DIR_INIT: begin
                    pos_x      <= next_x;
                    pos_y      <= next_y;
                    pos_off    <= off_board;
                    run        <= '0;
                    board_addr <= {next_y[2:0], next_x[2:0]};
                    state      <= STEP;
                end
                STEP: state <= pos_off ? NEXT_DIR : CHECK;
                CHECK: begin
                    if (board_rdata == opp) begin
                        run        <= run + 3'd1;
                        pos_x      <= next_x;
                        pos_y      <= next_y;
                        pos_off    <= off_board;
                        board_addr <= {next_y[2:0], next_x[2:0]};
                        state      <= STEP;
                    end else if ((board_rdata == own) && (run != '0)) begin
                        // First flip is issued on entry, so FLIP lasts exactly run cycles.
                        any         <= 1'b1;
                        flips       <= run;
                        pos_x       <= next_x;
                        pos_y       <= next_y;
                        board_addr  <= {next_y[2:0], next_x[2:0]};
                        board_wdata <= own;
                        board_we    <= 1'b1;
                        state       <= FLIP;
                    end else begin
                        state <= NEXT_DIR;
                    end
                end
                FLIP: begin
                    if (flips == 3'd1) begin
                        state <= NEXT_DIR;
                    end else begin
                        flips       <= flips - 3'd1;
                        pos_x       <= next_x;
                        pos_y       <= next_y;
                        board_addr  <= {next_y[2:0], next_x[2:0]};
                        board_wdata <= own;
                        board_we    <= 1'b1;
                    end
                end
                NEXT_DIR: begin
                    if (dir == 3'd7) begin
                        if (any) begin
                            board_addr  <= {tgt_y, tgt_x};
                            board_wdata <= own;
                            board_we    <= 1'b1;
                            state       <= PLACE;
                        end else begin
                            invalid <= 1'b1;
                            busy    <= 1'b0;
                            state   <= REJECT;
                        end
                    end else begin
                        dir   <= dir + 3'd1;
                        state <= DIR_INIT;
                    end
                end
                PLACE: begin
                    ack   <= 1'b1;
                    state <= ACKS;
                end
                ACKS: state <= DONE;
                DONE: begin
                    if (!new_move) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                REJECT: begin
                    if (!new_move) begin
                        state <= IDLE;
                    end else if (go && !go_q) begin
                        tgt_x      <= cursor_x;
                        tgt_y      <= cursor_y;
                        side       <= player_t'(player);
                        board_addr <= {cursor_y, cursor_x};
                        busy       <= 1'b1;
                        state      <= RD_TGT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_move_validator.sv
// Directed bench for move_validator with a 1-cycle-latency board RAM model.
module tb_move_validator;
    import othello_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       new_move;
    logic       player;
    logic       go;
    logic [2:0] cursor_x;
    logic [2:0] cursor_y;
    logic [1:0] board_rdata;
    logic [5:0] board_addr;
    logic [1:0] board_wdata;
    logic       board_we;
    logic       ack;
    logic       invalid;
    logic       busy;

    logic [1:0] mem      [64];
    logic [1:0] init_mem [64];
    logic       load = 1'b0;
    int         wlog[$];
    int         ack_cnt = 0;
    int         inv_cnt = 0;
    int         checks  = 0;
    int         errors  = 0;

    move_validator dut (
        .clock       (clock),
        .reset       (reset),
        .new_move    (new_move),
        .player      (player),
        .go          (go),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .board_rdata (board_rdata),
        .board_addr  (board_addr),
        .board_wdata (board_wdata),
        .board_we    (board_we),
        .ack         (ack),
        .invalid     (invalid),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (load) begin
            mem <= init_mem;
        end else if (board_we) begin
            mem[board_addr] <= board_wdata;
            wlog.push_back(int'({board_addr, board_wdata}));
        end
        board_rdata <= mem[board_addr];
        if (ack)     ack_cnt <= ack_cnt + 1;
        if (invalid) inv_cnt <= inv_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int wr(input int x, input int y, input int c);
        return ((y * 8 + x) << 2) | c;
    endfunction

    function automatic int log_at(input int i);
        return (i < wlog.size()) ? wlog[i] : -1;
    endfunction

    task automatic clear_board();
        foreach (init_mem[i]) init_mem[i] = CELL_EMPTY;
    endtask

    task automatic put(input int x, input int y, input logic [1:0] c);
        init_mem[y * 8 + x] = c;
    endtask

    task automatic opening();
        clear_board();
        put(3, 3, CELL_WHITE);
        put(4, 4, CELL_WHITE);
        put(4, 3, CELL_BLACK);
        put(3, 4, CELL_BLACK);
    endtask

    task automatic load_board();
        @(negedge clock) load = 1'b1;
        @(negedge clock) load = 1'b0;
    endtask

    // Returns 1 for ack, 2 for invalid, 0 on timeout.
    task automatic wait_result(output int got, output int cycles);
        got = 0;
        cycles = 0;
        while (got == 0 && cycles < 200) begin
            @(negedge clock);
            cycles++;
            if (ack) got = 1;
            else if (invalid) got = 2;
        end
    endtask

    task automatic run_move(input int x, input int y, input logic pl,
                            output int got, output int cycles);
        @(negedge clock);
        cursor_x = 3'(x);
        cursor_y = 3'(y);
        player   = pl;
        new_move = 1'b1;
        wait_result(got, cycles);
    endtask

    task automatic end_move();
        @(negedge clock) new_move = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    int n, a0, i0, got, cyc, addr_bad;

    initial begin
        reset    = 1'b0;
        new_move = 1'b0;
        player   = 1'b0;
        go       = 1'b0;
        cursor_x = '0;
        cursor_y = '0;
        repeat (3) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_ack", ack, 0);
        check("rst_invalid", invalid, 0);
        check("rst_we", board_we, 0);
        check("rst_addr", board_addr, 0);
        check("rst_state", int'(dut.state), int'(IDLE));
        reset = 1'b1;

        // Black at (3,2) from the opening: one flip then placement
        opening();
        load_board();
        n = wlog.size(); a0 = ack_cnt; i0 = inv_cnt;
        run_move(3, 2, 1'b0, got, cyc);
        check("t1_result", got, 1);
        check("t1_latency", int'(cyc <= 150), 1);
        check("t1_busy_during_ack", busy, 1);
        end_move();
        check("t1_nwrites", wlog.size() - n, 2);
        check("t1_w0", log_at(n), wr(3, 3, 1));
        check("t1_w1", log_at(n + 1), wr(3, 2, 1));
        check("t1_acks", ack_cnt - a0, 1);
        check("t1_invalids", inv_cnt - i0, 0);
        check("t1_busy_after", busy, 0);

        // Black at (0,0) rejected, then retried at (3,2) with a go edge
        opening();
        load_board();
        n = wlog.size(); a0 = ack_cnt; i0 = inv_cnt;
        run_move(0, 0, 1'b0, got, cyc);
        check("t2_result", got, 2);
        repeat (3) @(negedge clock);
        check("t2_busy_reject", busy, 0);
        check("t2_state_reject", int'(dut.state), int'(REJECT));
        check("t2_nwrites_rej", wlog.size() - n, 0);
        check("t2_invalids", inv_cnt - i0, 1);
        cursor_x = 3'd3;
        cursor_y = 3'd2;
        go = 1'b1;
        wait_result(got, cyc);
        check("t2_retry_result", got, 1);
        go = 1'b0;
        end_move();
        check("t2_nwrites", wlog.size() - n, 2);
        check("t2_w0", log_at(n), wr(3, 3, 1));
        check("t2_w1", log_at(n + 1), wr(3, 2, 1));
        check("t2_acks", ack_cnt - a0, 1);

        // Black at occupied (3,3): quick reject, only the target is addressed
        opening();
        load_board();
        n = wlog.size();
        @(negedge clock);
        cursor_x = 3'd3;
        cursor_y = 3'd3;
        player   = 1'b0;
        new_move = 1'b1;
        got = 0; cyc = 0; addr_bad = 0;
        while (got == 0 && cyc < 10) begin
            @(negedge clock);
            cyc++;
            if (board_addr != 6'd27) addr_bad++;
            if (invalid) got = 2;
        end
        check("t3_result", got, 2);
        check("t3_within3", int'(cyc <= 3), 1);
        check("t3_addr_only_target", addr_bad, 0);
        end_move();
        check("t3_nwrites", wlog.size() - n, 0);
        check("t3_state_idle", int'(dut.state), int'(IDLE));

        // Row 0 run of white to the edge: black at (4,0) cannot bracket
        clear_board();
        put(5, 0, CELL_WHITE);
        put(6, 0, CELL_WHITE);
        put(7, 0, CELL_WHITE);
        load_board();
        n = wlog.size();
        run_move(4, 0, 1'b0, got, cyc);
        check("t4_result", got, 2);
        end_move();
        check("t4_nwrites", wlog.size() - n, 0);

        // White at (4,4) captures two north and one west; east run hits the edge
        clear_board();
        put(4, 3, CELL_BLACK);
        put(4, 2, CELL_BLACK);
        put(4, 1, CELL_WHITE);
        put(3, 4, CELL_BLACK);
        put(2, 4, CELL_WHITE);
        put(5, 4, CELL_BLACK);
        put(6, 4, CELL_BLACK);
        put(7, 4, CELL_BLACK);
        load_board();
        n = wlog.size();
        run_move(4, 4, 1'b1, got, cyc);
        check("t5_result", got, 1);
        end_move();
        check("t5_nwrites", wlog.size() - n, 4);
        check("t5_w0", log_at(n), wr(4, 2, 2));
        check("t5_w1", log_at(n + 1), wr(4, 3, 2));
        check("t5_w2", log_at(n + 2), wr(3, 4, 2));
        check("t5_w3", log_at(n + 3), wr(4, 4, 2));

        // Reset asserted during FLIP, then a normal evaluation
        opening();
        load_board();
        @(negedge clock);
        cursor_x = 3'd3;
        cursor_y = 3'd2;
        player   = 1'b0;
        new_move = 1'b1;
        cyc = 0;
        while (board_we !== 1'b1 && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        check("t6_flip_seen", int'(dut.state), int'(FLIP));
        reset    = 1'b0;
        new_move = 1'b0;
        @(negedge clock);
        check("t6_busy", busy, 0);
        check("t6_we", board_we, 0);
        check("t6_state", int'(dut.state), int'(IDLE));
        reset = 1'b1;
        opening();
        load_board();
        n = wlog.size();
        run_move(3, 2, 1'b0, got, cyc);
        check("t6_result", got, 1);
        end_move();
        check("t6_nwrites", wlog.size() - n, 2);
        check("t6_w0", log_at(n), wr(3, 3, 1));
        check("t6_w1", log_at(n + 1), wr(3, 2, 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
